lif_scheduler: RTL
==================

# lif_scheduler

Time-multiplexed controller that shares one leaky-integrate-and-fire (LIF) update datapath among N virtual neurons. Each neuron has a membrane state, an input current and a refractory counter held in per-neuron registers. On each `start` pulse the block sequences through neurons 0..N-1, one update per clock, then reports a registered spike vector. It sits between the chip-level I/O wrapper and the neuron storage, replacing a bank of N free-running `lif` instances with a single scheduled datapath.

## Interface
Parameters:
- `N`, 4, number of virtual neurons (2..16)
- `WIDTH`, 8, bit width of membrane state and current
- `THRESHOLD`, 200, spike threshold (unsigned, < 2^WIDTH)
- `REFRACT`, 2, number of timesteps a neuron is held at 0 after spiking (0..15)

Ports:
- `clk`  in  1  clock; all state changes on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request one timestep (update all N neurons)
- `cur_we`  in  1  current-register write enable
- `cur_addr`  in  clog2(N)  neuron index for current write
- `cur_data`  in  WIDTH  current value to write
- `rd_addr`  in  clog2(N)  neuron index for state readout
- `rd_state`  out  WIDTH  membrane state of neuron `rd_addr` (combinational read of register)
- `busy`  out  1  high while the update sequence runs
- `done`  out  1  one-cycle pulse when a timestep completes
- `spikes`  out  N  spike vector of the last completed timestep

## Operation
- Reset: all states, currents, refractory counters, `spikes`, `busy`, `done` = 0; FSM to IDLE.
- FSM states: IDLE, UPDATE, DONE.
  - IDLE: `start`=1 -> UPDATE with index=0.
  - UPDATE: update neuron[index]; index = N-1 -> DONE, else index+1.
  - DONE: `done`=1; `spikes` loaded from the per-timestep spike accumulator; `start`=1 -> UPDATE (index=0), else IDLE.
- `start` ignored in UPDATE (no queuing).
- Per-neuron update (s = stored state, c = stored current, r = refractory counter):
  - r != 0: state <- 0, r <- r-1, spike bit 0.
  - r = 0 and s >= THRESHOLD: spike bit 1, state <- sat(c), r <- REFRACT.
  - otherwise: spike bit 0, state <- sat(c + (s >> 1)).
  - sat(): sum computed at WIDTH+1 bits, clamped to 2^WIDTH-1.
- Spike accumulator cleared on entering UPDATE at index 0; bit i set during neuron i's update.
- Current writes accepted in any state. A write to neuron i in the same cycle as neuron i's update: update uses the old current; new value applies from the next timestep.
- `rd_state` reflects the register value; mid-sequence it shows updated values for neurons already processed.

## Timing
- `start` sampled at edge T0 (in IDLE) -> `busy`=1 for cycles T0+1..T0+N (UPDATE); `done`=1 and new `spikes` visible in cycle T0+N+1; `busy`=0 in DONE.
- Back-to-back: `start` held high gives one timestep every N+1 cycles.
- `spikes` stable between DONE cycles.
- `rst` asserted mid-sequence: all outputs clear immediately (asynchronous), no `done` is issued, and the partial timestep is discarded.
- Latency from current write to effect: the next UPDATE of that neuron after the write edge.

## Test plan
Parameters N=4, WIDTH=8, THRESHOLD=200, REFRACT=2.
- Reset, all currents 0, pulse `start` -> `busy` high 4 cycles, `done` in cycle 5, `spikes`=0000, all states 0.
- current[0]=150, six timesteps -> state0 = 150, 225, 150 (spike, `spikes`=0001), 0, 0, 150; `spikes`=0000 on all steps except the third.
- current[1]=199, two timesteps -> state1 = 199, then 255 (saturated, no spike); third timestep -> `spikes`=0010.
- `start` pulsed during UPDATE -> ignored, exactly one `done`; `start` held high through DONE -> next UPDATE begins in the following cycle, `done` period = 5 cycles.
- Write current[2]=100 in the cycle neuron 2 is updated (previous current 10, state 0) -> state2 = 10 after this timestep, 105 after the next.
- Assert `rst` while index=2 -> `busy`, `done`, `spikes`, `rd_state` immediately 0; no `done` follows; the next `start` runs a clean sequence.

Source files
------------

// File: rtl/lif_scheduler_if.sv
// Bus bundle between the chip I/O wrapper and lif_scheduler: timestep request,
// current-register writes, state readout and timestep status.
interface lif_scheduler_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    localparam int AW = $clog2(N);

    logic             start;
    logic             cur_we;
    logic [AW-1:0]    cur_addr;
    logic [WIDTH-1:0] cur_data;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_state;
    logic             busy;
    logic             done;
    logic [N-1:0]     spikes;

    modport master (
        output start, cur_we, cur_addr, cur_data, rd_addr,
        input  rd_state, busy, done, spikes
    );

    modport slave (
        input  start, cur_we, cur_addr, cur_data, rd_addr,
        output rd_state, busy, done, spikes
    );
endinterface

// File: rtl/lif_scheduler.sv
// Time-multiplexed LIF controller: one shared update datapath walks neurons
// 0..N-1 per timestep and publishes the timestep's spike vector.
module lif_scheduler #(
    parameter int N         = 4,
    parameter int WIDTH     = 8,
    parameter int THRESHOLD = 200,
    parameter int REFRACT   = 2
) (
    input logic            clk,
    input logic            rst,
    lif_scheduler_if.slave bus
);
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [AW-1:0]    r_idx;
    logic [WIDTH-1:0] r_mem [N];
    logic [WIDTH-1:0] r_cur [N];
    logic [3:0]       r_ref [N];
    logic [N-1:0]     r_acc;
    logic [N-1:0]     r_spikes;

    logic             w_busy;
    logic             w_done;
    logic             w_begin;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_c;
    logic [3:0]       w_r;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_new;
    logic [3:0]       w_r_new;
    logic             w_spk;
    logic [N-1:0]     w_acc_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_begin = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next  = UPDATE;
                    w_begin = 1'b1;
                end
            end
            UPDATE: begin
                w_busy = 1'b1;
                if (r_idx == LAST) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                if (bus.start) begin
                    w_next  = UPDATE;
                    w_begin = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Shared datapath for the neuron selected by r_idx
    always_comb begin
        w_s     = r_mem[r_idx];
        w_c     = r_cur[r_idx];
        w_r     = r_ref[r_idx];
        w_sum   = {1'b0, w_c} + {2'b00, w_s[WIDTH-1:1]};
        w_new   = '0;
        w_r_new = w_r;
        w_spk   = 1'b0;
        if (w_r != 4'd0) begin
            w_r_new = w_r - 4'd1;
        end else if (w_s >= WIDTH'(THRESHOLD)) begin
            w_spk   = 1'b1;
            w_new   = w_c;
            w_r_new = 4'(REFRACT);
        end else begin
            w_new = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
        end
        w_acc_set        = r_acc;
        w_acc_set[r_idx] = w_spk;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx    <= '0;
            r_acc    <= '0;
            r_spikes <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                r_mem[i] <= '0;
                r_cur[i] <= '0;
                r_ref[i] <= '0;
            end
        end else begin
            if (w_begin) begin
                r_idx <= '0;
                r_acc <= '0;
            end else if (r_state == UPDATE) begin
                r_mem[r_idx] <= w_new;
                r_ref[r_idx] <= w_r_new;
                r_acc        <= w_acc_set;
                r_idx        <= r_idx + AW'(1);
                // Published on entry to DONE so the last neuron's bit is included
                if (r_idx == LAST) begin
                    r_spikes <= w_acc_set;
                end
            end
            if (bus.cur_we) begin
                r_cur[bus.cur_addr] <= bus.cur_data;
            end
        end
    end

    assign bus.rd_state = r_mem[bus.rd_addr];
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.spikes   = r_spikes;
endmodule
